// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte producers.
// Accepts one byte per valid/ready handshake, pulses send, and tracks td_busy until the frame ends.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 send,
    input  logic                 td_busy,
    output logic [2:0]           grant_id,
    output logic                 arb_busy,
    output logic                 timeout_err
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned SW = IW + 1;
    localparam logic [7:0]  TO_LIM = 8'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            send_q, send_d;
    logic [2:0]      grant_q, grant_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            terr_q, terr_d;

    logic [7:0]      req_bytes [NUM_REQ];
    logic            found;
    logic [IW-1:0]   winner;
    logic [SW-1:0]   cand;
    logic            grant_ok;
    logic [7:0]      cnt_inc;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_bytes[g] = req_data[8*g +: 8];
    end

    // Scan from rr_q upward with wrap; the first valid requester wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_q} + SW'(i);
            if (cand >= SW'(NUM_REQ)) begin
                cand = cand - SW'(NUM_REQ);
            end
            if (!found && req_valid[cand[IW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IW-1:0];
            end
        end
    end

    assign grant_ok = (state_q == IDLE) && !td_busy && found;
    assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        req_ready = '0;
        if (grant_ok) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        send_d    = 1'b0;
        grant_d   = grant_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        terr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_ok) begin
                    tx_data_d = req_bytes[winner];
                    grant_d   = 3'(winner);
                    rr_d      = (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                    send_d    = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (td_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    // Timeout is decided on the edge where the counter reaches
                    // BUSY_TIMEOUT-1, so the error pulse appears in the following cycle.
                    cnt_d = cnt_inc;
                    if (cnt_inc >= TO_LIM) begin
                        terr_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!td_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            tx_data_q <= '0;
            send_q    <= 1'b0;
            grant_q   <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            send_q    <= send_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            terr_q    <= terr_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign send        = send_q;
    assign grant_id    = grant_q;
    assign arb_busy    = (state_q != IDLE);
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: producer queues, a transmitter model and a
// scoreboard of expected (grant, byte) pairs checked on every send pulse.
module tb_uart_tx_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned BT    = 4;
    localparam int unsigned FRAME = 6;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           send;
    logic           td_busy;
    logic [2:0]     grant_id;
    logic           arb_busy;
    logic           timeout_err;

    logic           mbusy;
    int             mcnt;
    logic           td_force = 1'b0;
    logic           tx_alive = 1'b1;

    typedef struct packed {
        logic [2:0] id;
        logic [7:0] data;
    } exp_t;

    logic [7:0]     pq [N][$];
    exp_t           exp_q[$];
    logic [N-1:0]   acc_n = '0;

    int tests = 0;
    int fails = 0;
    int n_exp = 0;
    int n_send = 0;
    int cyc = 0;
    int last_send_cyc = 0;
    logic spc_on = 1'b0;
    logic spc_have = 1'b0;
    logic prev_send = 1'b0;
    logic hold_ok = 1'b0;
    logic [7:0] hold_v = '0;

    assign td_busy = mbusy | td_force;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ     (N),
        .BUSY_TIMEOUT(BT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_data    (tx_data),
        .send       (send),
        .td_busy    (td_busy),
        .grant_id   (grant_id),
        .arb_busy   (arb_busy),
        .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_grant(input int id, input logic [7:0] b);
        exp_q.push_back({3'(id), b});
        n_exp++;
    endtask

    function automatic bit pq_empty();
        for (int i = 0; i < N; i++) begin
            if (pq[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (k < 300 && !(arb_busy === 1'b0 && td_busy === 1'b0 && exp_q.size() == 0 && pq_empty())) begin
            @(negedge clk);
            k++;
        end
        tests++;
        assert (k < 300) else begin
            fails++;
            $error("FAIL %s_idle observed=%0d cycles expected=<300", tag, k);
        end
    endtask

    // Transmitter model: td_busy rises on the edge that samples send and lasts FRAME cycles.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mbusy <= 1'b0;
            mcnt  <= 0;
        end else if (send && tx_alive) begin
            mbusy <= 1'b1;
            mcnt  <= FRAME;
        end else if (mbusy) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) mbusy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        #3;
        acc_n = req_ready & req_valid;
    end

    // Producers: drop the accepted byte, present the next one.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_n[i] && pq[i].size() > 0) void'(pq[i].pop_front());
            req_valid[i]       = (pq[i].size() > 0);
            req_data[8*i +: 8] = (pq[i].size() > 0) ? pq[i][0] : 8'h00;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (send) begin
            n_send++;
            check("send_pulse_width", 32'(prev_send), 32'd0);
            if (spc_on && spc_have) check("send_spacing", 32'(cyc - last_send_cyc), 32'(FRAME + 3));
            spc_have      = 1'b1;
            last_send_cyc = cyc;
            tests++;
            assert (exp_q.size() > 0) else begin
                fails++;
                $error("FAIL sb_unexpected_send observed=grant %0d data %0h expected=no send", grant_id, tx_data);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("grant_id", 32'(grant_id), 32'(e.id));
                check("tx_data", 32'(tx_data), 32'(e.data));
                hold_v  = e.data;
                hold_ok = 1'b1;
            end
        end else if (!arb_busy) begin
            hold_ok = 1'b0;
        end else if (hold_ok && td_busy) begin
            check("tx_data_hold", 32'(tx_data), 32'(hold_v));
        end
        prev_send = send;
    end

    initial begin
        #200000;
        $error("FAIL watchdog observed=simulation still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int n;
        #1 reset = 1'b1;
        #2;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_send", 32'(send), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_arb_busy", 32'(arb_busy), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single requester 2.
        wait_idle("t1_pre");
        pq[2].push_back(8'hA5);
        expect_grant(2, 8'hA5);
        @(negedge clk);
        check("t1_req_ready", 32'(req_ready), 32'b0100);
        @(negedge clk);
        check("t1_req_ready_after", 32'(req_ready), 32'd0);
        check("t1_arb_busy", 32'(arb_busy), 32'd1);
        wait_idle("t1");

        // rr_ptr=3: req 3 before req 1; then wrap so req 0 beats req 1.
        pq[3].push_back(8'h33);
        pq[1].push_back(8'h31);
        expect_grant(3, 8'h33);
        expect_grant(1, 8'h31);
        wait_idle("rr_a");
        pq[3].push_back(8'h43);
        expect_grant(3, 8'h43);
        wait_idle("rr_b");
        pq[0].push_back(8'h40);
        pq[1].push_back(8'h41);
        expect_grant(0, 8'h40);
        expect_grant(1, 8'h41);
        wait_idle("rr_c");

        // Reset in WAIT_DONE; rr_ptr is 2 beforehand.
        pq[1].push_back(8'h77);
        expect_grant(1, 8'h77);
        k = 0;
        while (k < 60 && !(arb_busy && td_busy && n_send == n_exp)) begin
            @(negedge clk);
            k++;
        end
        check("rst_mid_reach_wait_done", 32'(k < 60), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_arb_busy", 32'(arb_busy), 32'd0);
        check("rst_mid_send", 32'(send), 32'd0);
        check("rst_mid_tx_data", 32'(tx_data), 32'd0);
        check("rst_mid_grant_id", 32'(grant_id), 32'd0);
        #1 reset = 1'b0;

        // All four continuously valid: strict rotation from req 0.
        spc_have = 1'b0;
        spc_on   = 1'b1;
        pq[0].push_back(8'h10);
        pq[0].push_back(8'h14);
        pq[1].push_back(8'h11);
        pq[2].push_back(8'h12);
        pq[3].push_back(8'h13);
        expect_grant(0, 8'h10);
        expect_grant(1, 8'h11);
        expect_grant(2, 8'h12);
        expect_grant(3, 8'h13);
        expect_grant(0, 8'h14);
        wait_idle("all4");
        spc_on = 1'b0;

        // Transmitter never answers: timeout, then next requester is served.
        tx_alive = 1'b0;
        pq[1].push_back(8'h55);
        pq[2].push_back(8'h56);
        expect_grant(1, 8'h55);
        expect_grant(2, 8'h56);
        k = 0;
        while (k < 60 && send !== 1'b1) begin
            @(negedge clk);
            k++;
        end
        check("to_send_seen", 32'(k < 60), 32'd1);
        n = 0;
        while (n < 20 && timeout_err !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        tx_alive = 1'b1;
        check("to_latency", 32'(n), 32'(BT));
        check("to_arb_idle", 32'(arb_busy), 32'd0);
        @(negedge clk);
        check("to_pulse_width", 32'(timeout_err), 32'd0);
        wait_idle("timeout");

        // td_busy held externally blocks the grant.
        td_force = 1'b1;
        pq[0].push_back(8'h66);
        expect_grant(0, 8'h66);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("blk_req_ready", 32'(req_ready), 32'd0);
        end
        #1 td_force = 1'b0;
        #1;
        check("blk_release_ready", 32'(req_ready), 32'b0001);
        wait_idle("blk");

        check("sends_total", 32'(n_send), 32'(n_exp));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
